// File: rtl/sram_copy_pkg.sv
// Shared types and defaults for the SRAM block-copy master.
package sram_copy_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StWait,
    StWr,
    StFin
  } state_e;

  localparam int unsigned ADDR_W_DEF = 10;
  localparam int unsigned DATA_W_DEF = 32;

  localparam logic [DATA_W_DEF/8-1:0] BE_ALL = '1;

endpackage

// File: rtl/sram_copy_master.sv
// Avalon-MM master copying a block of words forward within one port of a dual-port SRAM.
// Every output is a register loaded from next-state logic, so nothing toggles combinationally.
module sram_copy_master
  import sram_copy_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                abort,
  input  logic [ADDR_W-1:0]   src_addr,
  input  logic [ADDR_W-1:0]   dst_addr,
  input  logic [ADDR_W:0]     len,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic [ADDR_W:0]     words_done,
  output logic [ADDR_W-1:0]   address,
  output logic [DATA_W/8-1:0] byteenable,
  output logic                chipselect,
  output logic                write,
  output logic [DATA_W-1:0]   writedata,
  output logic                clken,
  input  logic [DATA_W-1:0]   readdata
);

  localparam int unsigned BeW = DATA_W / 8;
  localparam logic [BeW-1:0] BeAll = (BeW == $bits(BE_ALL)) ? BeW'(BE_ALL) : {BeW{1'b1}};
  localparam logic [1:0] LatLast = 2'(READ_LATENCY - 1);

  state_e              r_state, w_state_d;
  logic [ADDR_W-1:0]   r_src, w_src_d;
  logic [ADDR_W-1:0]   r_dst, w_dst_d;
  logic [ADDR_W:0]     r_len, w_len_d;
  logic [ADDR_W:0]     r_words, w_words_d;
  logic                r_abort_seen, w_abort_seen_d;
  logic                r_aborted, w_aborted_d;
  logic [1:0]          r_wait_cnt, w_wait_d;
  logic [DATA_W-1:0]   r_wdata, w_wdata_d;
  logic                r_busy, w_busy_d;
  logic                r_done, w_done_d;
  logic                r_cs, w_cs_d;
  logic                r_we, w_we_d;
  logic [ADDR_W-1:0]   r_addr, w_addr_d;
  logic [BeW-1:0]      r_be, w_be_d;
  logic                r_clken;
  logic                w_abort_any;

  assign w_abort_any = r_abort_seen | abort;

  always_comb begin
    w_state_d      = r_state;
    w_src_d        = r_src;
    w_dst_d        = r_dst;
    w_len_d        = r_len;
    w_words_d      = r_words;
    w_abort_seen_d = r_abort_seen;
    w_aborted_d    = r_aborted;
    w_wait_d       = r_wait_cnt;
    w_wdata_d      = r_wdata;

    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_src_d        = src_addr;
          w_dst_d        = dst_addr;
          w_len_d        = len;
          w_words_d      = '0;
          w_abort_seen_d = 1'b0;
          w_aborted_d    = 1'b0;
          w_state_d      = (len == '0) ? StFin : StRd;
        end
      end
      StRd: begin
        w_wait_d  = '0;
        w_state_d = StWait;
      end
      StWait: begin
        if (r_wait_cnt == LatLast) begin
          w_wdata_d = readdata;
          w_state_d = StWr;
        end else begin
          w_wait_d = r_wait_cnt + 2'd1;
        end
      end
      StWr: begin
        w_words_d = r_words + 1'b1;
        w_src_d   = r_src + 1'b1;
        w_dst_d   = r_dst + 1'b1;
        // A copy that finishes its last word counts as complete even if abort arrived too.
        if (w_words_d == r_len) begin
          w_state_d = StFin;
        end else if (w_abort_any) begin
          w_aborted_d = 1'b1;
          w_state_d   = StFin;
        end else begin
          w_state_d = StRd;
        end
      end
      StFin:   w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase

    if (r_busy && abort) begin
      w_abort_seen_d = 1'b1;
    end

    w_busy_d = (w_state_d == StRd) || (w_state_d == StWait) || (w_state_d == StWr);
    w_done_d = (w_state_d == StFin);
    w_cs_d   = (w_state_d == StRd) || (w_state_d == StWr);
    w_we_d   = (w_state_d == StWr);
    w_be_d   = w_cs_d ? BeAll : '0;
    w_addr_d = '0;
    if (w_state_d == StRd) begin
      w_addr_d = w_src_d;
    end else if (w_state_d == StWr) begin
      w_addr_d = w_dst_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= StIdle;
      r_src        <= '0;
      r_dst        <= '0;
      r_len        <= '0;
      r_words      <= '0;
      r_abort_seen <= 1'b0;
      r_aborted    <= 1'b0;
      r_wait_cnt   <= '0;
      r_wdata      <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_cs         <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_be         <= '0;
      r_clken      <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_src        <= w_src_d;
      r_dst        <= w_dst_d;
      r_len        <= w_len_d;
      r_words      <= w_words_d;
      r_abort_seen <= w_abort_seen_d;
      r_aborted    <= w_aborted_d;
      r_wait_cnt   <= w_wait_d;
      r_wdata      <= w_wdata_d;
      r_busy       <= w_busy_d;
      r_done       <= w_done_d;
      r_cs         <= w_cs_d;
      r_we         <= w_we_d;
      r_addr       <= w_addr_d;
      r_be         <= w_be_d;
      r_clken      <= 1'b1;
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign aborted    = r_aborted;
  assign words_done = r_words;
  assign address    = r_addr;
  assign byteenable = r_be;
  assign chipselect = r_cs;
  assign write      = r_we;
  assign writedata  = r_wdata;
  assign clken      = r_clken;

endmodule

// File: tb/tb_sram_copy_master.sv
// Randomized self-checking bench: SRAM model plus a forward-copy reference memory.
module tb_sram_copy_master;

  localparam int Depth = 1024;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [9:0]  src_addr = '0;
  logic [9:0]  dst_addr = '0;
  logic [10:0] len = '0;
  logic        busy, done, aborted, chipselect, write, clken;
  logic [10:0] words_done;
  logic [9:0]  address;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic [31:0] readdata;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sram_copy_master #(
    .ADDR_W      (10),
    .DATA_W      (32),
    .READ_LATENCY(1)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .abort     (abort),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
    .words_done(words_done),
    .address   (address),
    .byteenable(byteenable),
    .chipselect(chipselect),
    .write     (write),
    .writedata (writedata),
    .clken     (clken),
    .readdata  (readdata)
  );

  // SRAM model (read latency 1) and reference memory.
  logic [31:0] mem     [Depth];
  logic [31:0] ref_mem [Depth];
  logic        fill = 1'b0;

  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < Depth; i++) mem[i] <= ref_mem[i];
    end else if (chipselect) begin
      if (write) mem[address] <= writedata;
      else       readdata <= mem[address];
    end
  end

  // Bus monitor.
  int          busy_cnt, done_cnt, be_bad;
  int unsigned rd_q[$];
  int unsigned wr_q[$];
  logic        mon_clr = 1'b0;

  always @(negedge clk) begin
    if (mon_clr) begin
      busy_cnt <= 0;
      done_cnt <= 0;
      be_bad   <= 0;
      rd_q.delete();
      wr_q.delete();
    end else begin
      if (busy) busy_cnt <= busy_cnt + 1;
      if (done) done_cnt <= done_cnt + 1;
      if (chipselect && byteenable !== 4'hF) be_bad <= be_bad + 1;
      if (chipselect && !write) rd_q.push_back(int'(address));
      if (chipselect && write) wr_q.push_back(int'(address));
    end
  end

  task automatic load_mem();
    fill = 1'b1;
    @(negedge clk);
    #1 fill = 1'b0;
  endtask

  task automatic ref_copy(input int s, input int d, input int n);
    for (int i = 0; i < n; i++) ref_mem[(d + i) % Depth] = ref_mem[(s + i) % Depth];
  endtask

  function automatic int mem_diff();
    int c = 0;
    for (int i = 0; i < Depth; i++) if (mem[i] !== ref_mem[i]) c++;
    return c;
  endfunction

  function automatic int seq_bad(input int s, input int n, input int is_wr);
    int c = 0;
    int sz = is_wr ? wr_q.size() : rd_q.size();
    if (sz != n) return 1 + sz;
    for (int i = 0; i < n; i++) begin
      if ((is_wr ? wr_q[i] : rd_q[i]) != int'((s + i) % Depth)) c++;
    end
    return c;
  endfunction

  task automatic mon_reset();
    mon_clr = 1'b1;
    @(negedge clk);
    #1 mon_clr = 1'b0;
  endtask

  // Runs one copy; done_k is the cycle done is seen (1 = first cycle after start), -1 on timeout.
  task automatic do_copy(input int s, input int d, input int n, input int abort_k,
                         input int ign_k, output int done_k);
    mon_reset();
    start = 1'b1;
    src_addr = 10'(s);
    dst_addr = 10'(d);
    len = 11'(n);
    done_k = -1;
    for (int k = 1; k <= 5000; k++) begin
      @(negedge clk);
      start = (k == ign_k);
      abort = (k == abort_k);
      if (k == ign_k) begin
        src_addr = 10'(s + 77);
        dst_addr = 10'(d + 33);
        len = 11'd3;
      end
      if (done) begin
        done_k = k;
        break;
      end
    end
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if ({busy, done, aborted, chipselect, write, clken, byteenable, address, words_done,
         writedata} !== '0) begin
      $display("FAIL reset_outputs: got busy=%b done=%b cs=%b we=%b clken=%b addr=%h wd=%h, want 0",
               busy, done, chipselect, write, clken, address, writedata);
      n_errors++;
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (clken !== 1'b1) begin
      $display("FAIL clken_after_reset: got %b want 1", clken);
      n_errors++;
    end
    n_checks++;
    if (busy !== 1'b0 || chipselect !== 1'b0) begin
      $display("FAIL idle_after_reset: got busy=%b cs=%b want 0 0", busy, chipselect);
      n_errors++;
    end
  endtask

  task automatic test_idle_abort();
    mon_reset();
    abort = 1'b1;
    repeat (3) @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
    #1;
    n_checks++;
    if (busy_cnt != 0 || done_cnt != 0 || rd_q.size() + wr_q.size() != 0) begin
      $display("FAIL idle_abort: got busy=%0d done=%0d acc=%0d want 0 0 0",
               busy_cnt, done_cnt, rd_q.size() + wr_q.size());
      n_errors++;
    end
  endtask

  task automatic test_normal();
    int dk;
    for (int i = 0; i < Depth; i++) ref_mem[i] = $urandom;
    for (int i = 0; i < 4; i++) ref_mem[16 + i] = 32'hA0 + 32'(i);
    load_mem();
    do_copy(16, 256, 4, -1, -1, dk);
    ref_copy(16, 256, 4);
    n_checks++;
    if (dk != 13) begin $display("FAIL normal_done_cycle: got %0d want 13", dk); n_errors++; end
    n_checks++;
    if (busy_cnt != 12) begin $display("FAIL normal_busy: got %0d want 12", busy_cnt); n_errors++; end
    n_checks++;
    if (done_cnt != 1) begin $display("FAIL normal_done_cnt: got %0d want 1", done_cnt); n_errors++; end
    n_checks++;
    if (aborted !== 1'b0 || words_done !== 11'd4) begin
      $display("FAIL normal_status: got aborted=%b words=%0d want 0 4", aborted, words_done);
      n_errors++;
    end
    n_checks++;
    if (mem_diff() != 0) begin
      $display("FAIL normal_mem: got %0d bad words want 0", mem_diff());
      n_errors++;
    end
    n_checks++;
    if (seq_bad(16, 4, 0) + seq_bad(256, 4, 1) + be_bad != 0) begin
      $display("FAIL normal_bus_seq: got %0d bad accesses want 0",
               seq_bad(16, 4, 0) + seq_bad(256, 4, 1) + be_bad);
      n_errors++;
    end
  endtask

  task automatic test_wrap();
    int dk;
    do_copy(1022, 0, 4, -1, -1, dk);
    ref_copy(1022, 0, 4);
    n_checks++;
    if (dk != 13) begin $display("FAIL wrap_done_cycle: got %0d want 13", dk); n_errors++; end
    n_checks++;
    if (seq_bad(1022, 4, 0) + seq_bad(0, 4, 1) != 0) begin
      $display("FAIL wrap_bus_seq: got %0d bad accesses want 0",
               seq_bad(1022, 4, 0) + seq_bad(0, 4, 1));
      n_errors++;
    end
    n_checks++;
    if (mem_diff() != 0) begin
      $display("FAIL wrap_mem: got %0d bad words want 0", mem_diff());
      n_errors++;
    end
  endtask

  task automatic test_empty();
    int dk;
    do_copy(5, 9, 0, -1, -1, dk);
    n_checks++;
    if (dk != 1 || done_cnt != 1) begin
      $display("FAIL empty_done: got cycle=%0d pulses=%0d want 1 1", dk, done_cnt);
      n_errors++;
    end
    n_checks++;
    if (busy_cnt != 0 || rd_q.size() + wr_q.size() != 0 || words_done !== 11'd0) begin
      $display("FAIL empty_quiet: got busy=%0d acc=%0d words=%0d want 0 0 0",
               busy_cnt, rd_q.size() + wr_q.size(), words_done);
      n_errors++;
    end
  endtask

  task automatic test_abort();
    int dk;
    // Word 2 occupies cycles 4 (RD), 5 (WAIT), 6 (WR).
    do_copy(64, 128, 8, 5, -1, dk);
    ref_copy(64, 128, 2);
    n_checks++;
    if (dk != 7 || done_cnt != 1) begin
      $display("FAIL abort_done: got cycle=%0d pulses=%0d want 7 1", dk, done_cnt);
      n_errors++;
    end
    n_checks++;
    if (aborted !== 1'b1 || words_done !== 11'd2) begin
      $display("FAIL abort_status: got aborted=%b words=%0d want 1 2", aborted, words_done);
      n_errors++;
    end
    n_checks++;
    if (seq_bad(64, 2, 0) + seq_bad(128, 2, 1) != 0 || mem_diff() != 0) begin
      $display("FAIL abort_access: got seq=%0d mem=%0d want 0 0",
               seq_bad(64, 2, 0) + seq_bad(128, 2, 1), mem_diff());
      n_errors++;
    end
  endtask

  task automatic test_ignored_start();
    int dk;
    do_copy(512, 768, 5, -1, 4, dk);
    ref_copy(512, 768, 5);
    n_checks++;
    if (dk != 16 || words_done !== 11'd5 || aborted !== 1'b0) begin
      $display("FAIL ign_start_status: got cycle=%0d words=%0d aborted=%b want 16 5 0",
               dk, words_done, aborted);
      n_errors++;
    end
    n_checks++;
    if (seq_bad(768, 5, 1) != 0 || mem_diff() != 0) begin
      $display("FAIL ign_start_mem: got seq=%0d mem=%0d want 0 0", seq_bad(768, 5, 1), mem_diff());
      n_errors++;
    end
  endtask

  task automatic test_reset_mid();
    int dk;
    mon_reset();
    start = 1'b1;
    src_addr = 10'h120;
    dst_addr = 10'h1A0;
    len = 11'd16;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, aborted, chipselect, write, clken, byteenable, address, words_done,
         writedata} !== '0) begin
      $display("FAIL reset_mid_outputs: got busy=%b cs=%b we=%b clken=%b addr=%h words=%0d want 0",
               busy, chipselect, write, clken, address, words_done);
      n_errors++;
    end
    // Writes commit at the edges closing cycles 3, 6 and 9.
    ref_copy(288, 416, 3);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    n_checks++;
    if (done_cnt != 0 || mem_diff() != 0) begin
      $display("FAIL reset_mid_partial: got done=%0d mem=%0d want 0 0", done_cnt, mem_diff());
      n_errors++;
    end
    do_copy(7, 9, 2, -1, -1, dk);
    ref_copy(7, 9, 2);
    n_checks++;
    if (dk != 7 || words_done !== 11'd2 || mem_diff() != 0) begin
      $display("FAIL reset_mid_recover: got cycle=%0d words=%0d mem=%0d want 7 2 0",
               dk, words_done, mem_diff());
      n_errors++;
    end
  endtask

  task automatic test_random();
    int dk, s, d, n;
    for (int it = 0; it < 7; it++) begin
      s = int'($urandom_range(0, Depth - 1));
      d = int'($urandom_range(0, Depth - 1));
      n = (it == 6) ? Depth : int'($urandom_range(1, 40));
      do_copy(s, d, n, -1, -1, dk);
      ref_copy(s, d, n);
      n_checks++;
      if (dk != 3 * n + 1 || busy_cnt != 3 * n || words_done !== 11'(n)) begin
        $display("FAIL rand_timing[%0d]: got cycle=%0d busy=%0d words=%0d want %0d %0d %0d",
                 it, dk, busy_cnt, words_done, 3 * n + 1, 3 * n, n);
        n_errors++;
      end
      n_checks++;
      if (seq_bad(s, n, 0) + seq_bad(d, n, 1) != 0 || mem_diff() != 0) begin
        $display("FAIL rand_copy[%0d]: got seq=%0d mem=%0d want 0 0 (s=%0d d=%0d n=%0d)",
                 it, seq_bad(s, n, 0) + seq_bad(d, n, 1), mem_diff(), s, d, n);
        n_errors++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_abort();
    test_normal();
    test_wrap();
    test_empty();
    test_abort();
    test_ignored_start();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
